// File: rtl/lsu_ram_master_if.sv
// rtl/lsu_ram_master_if.sv - request/response/RAM signal bundle for lsu_ram_master
//
// Purpose: groups the pipeline request handshake, the response handshake and
// the word-organised data RAM port into one bundle.
// Modports:
//   master - the load/store unit (drives req_ready, resp_*, ram_* except ram_rdata)
//   slave  - the surrounding pipeline + RAM (drives req_*, resp_ready, ram_rdata)
// Signals:
//   req_valid/req_ready         request handshake
//   req_we/size/unsigned/addr/wdata/rd   request payload
//   resp_valid/resp_ready       response handshake
//   resp_data/resp_rd/resp_ale  response payload
//   ram_en/we/addr/sel/wdata    RAM command, ram_rdata RAM read data

interface lsu_ram_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_ale;

    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [3:0]  ram_sel;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        input  resp_ready, ram_rdata,
        output req_ready, resp_valid, resp_data, resp_rd, resp_ale,
        output ram_en, ram_we, ram_addr, ram_sel, ram_wdata
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
        output resp_ready, ram_rdata,
        input  req_ready, resp_valid, resp_data, resp_rd, resp_ale,
        input  ram_en, ram_we, ram_addr, ram_sel, ram_wdata
    );
endinterface

// File: rtl/lsu_ram_master.sv
// rtl/lsu_ram_master.sv - single-outstanding load/store initiator for the data RAM
//
// Purpose: accepts one load/store at a time, performs a one-cycle RAM access
// with byte-lane select and lane-replicated store data, extracts and extends
// load data, and returns it through a valid/ready response.
// Optional feature macro: LSU_ALE_CHECK_EN (misaligned half/word -> resp_ale,
// no RAM access). Without it, misaligned offsets are truncated and never fault.
// Ports:
//   clk   - clock, all state changes on posedge
//   rst   - synchronous active-high reset
//   flush - cancels a pending response / blocks acceptance
//   bus   - lsu_ram_master_if.master (request, response and RAM port)

module lsu_ram_master (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    lsu_ram_master_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [4:0]  r_rd;
    logic [31:0] r_resp_data;

    logic        w_accept;
    logic        w_req_ale;
    logic [1:0]  w_off;
    logic [3:0]  w_sel;
    logic [31:0] w_store_data;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;

`ifdef LSU_ALE_CHECK_EN
    logic        r_ale;

    // Half needs addr[0]==0; word (size 10 or 11) needs addr[1:0]==0.
    always_comb begin
        w_req_ale = 1'b0;
        if (bus.req_size == 2'b01) begin
            w_req_ale = bus.req_addr[0];
        end else if (bus.req_size[1]) begin
            w_req_ale = (bus.req_addr[1:0] != 2'b00);
        end
    end
`else
    assign w_req_ale = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush wins over the response handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid && !flush) begin
                    w_next = w_req_ale ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_next = flush ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (flush || bus.resp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Effective byte offset inside the word. Half ignores addr[0] and word
    // ignores addr[1:0], so with alignment checking off a misaligned request
    // is silently truncated; with checking on it never reaches ACCESS.
    always_comb begin
        w_off = 2'b00;
        case (r_size)
            2'b00:   w_off = r_addr[1:0];
            2'b01:   w_off = {r_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

    always_comb begin
        w_sel        = 4'b1111;
        w_store_data = r_wdata;
        case (r_size)
            2'b00: begin
                w_sel        = 4'b0001 << w_off;
                w_store_data = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_sel        = 4'b0011 << w_off;
                w_store_data = {2{r_wdata[15:0]}};
            end
            default: begin
                w_sel        = 4'b1111;
                w_store_data = r_wdata;
            end
        endcase
    end

    assign w_shifted = bus.ram_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            2'b00:   w_load_data = r_unsigned ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = r_unsigned ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // Request capture and load-data capture at the closing edge of ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rd        <= 5'h0;
            r_resp_data <= 32'h0;
`ifdef LSU_ALE_CHECK_EN
            r_ale       <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_we        <= bus.req_we;
                r_size      <= bus.req_size;
                r_unsigned  <= bus.req_unsigned;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_rd        <= bus.req_rd;
                r_resp_data <= 32'h0;
`ifdef LSU_ALE_CHECK_EN
                r_ale       <= w_req_ale;
`endif
            end
            if (r_state == ST_ACCESS) begin
                r_resp_data <= r_we ? 32'h0 : w_load_data;
            end
        end
    end

    // Outputs depend only on registered state, never directly on req_*.
    always_comb begin
        bus.req_ready  = (r_state == ST_IDLE) && !rst;
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'h0;
        bus.resp_rd    = 5'h0;
        bus.resp_ale   = 1'b0;
        bus.ram_en     = 1'b0;
        bus.ram_we     = 1'b0;
        bus.ram_addr   = 32'h0;
        bus.ram_sel    = 4'b0000;
        bus.ram_wdata  = 32'h0;
        case (r_state)
            ST_ACCESS: begin
                bus.ram_en    = 1'b1;
                bus.ram_we    = r_we;
                bus.ram_addr  = {r_addr[31:2], 2'b00};
                bus.ram_sel   = w_sel;
                bus.ram_wdata = w_store_data;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = r_resp_data;
                bus.resp_rd    = r_rd;
`ifdef LSU_ALE_CHECK_EN
                bus.resp_ale   = r_ale;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_ram_master.sv
// tb/tb_lsu_ram_master.sv - self-checking bench for lsu_ram_master

module tb_lsu_ram_master;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    lsu_ram_master_if bus ();

    lsu_ram_master dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.master)
    );

`ifdef LSU_ALE_CHECK_EN
    localparam bit ALE_ON = 1'b1;
`else
    localparam bit ALE_ON = 1'b0;
`endif

    logic [31:0] ram_mem  [256];
    logic [31:0] gold_mem [256];
    logic        pre_en;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0103_0507) ^ 32'hA5C3_5A3C;
    endfunction

    // Bench RAM: lane-masked writes from the DUT, plus bench preloads.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(i);
        end else if (pre_en) begin
            ram_mem[pre_idx] <= pre_val;
        end else if (bus.ram_en && bus.ram_we) begin
            for (int i = 0; i < 4; i++)
                if (bus.ram_sel[i]) ram_mem[bus.ram_addr[9:2]][8*i +: 8] <= bus.ram_wdata[8*i +: 8];
        end
    end

    assign bus.ram_rdata = ram_mem[bus.ram_addr[9:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (arithmetic on the rules) ----------------
    function automatic bit m_ale(input int size, input int unsigned addr);
        if (!ALE_ON) return 1'b0;
        if (size == 1) return (addr % 2) != 0;
        if (size >= 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic int m_off(input int size, input int unsigned addr);
        if (size == 0) return int'(addr % 4);
        if (size == 1) return int'((addr % 4) / 2 * 2);
        return 0;
    endfunction

    function automatic logic [31:0] m_sel(input int size, input int unsigned addr);
        if (size == 0) return 32'(1 << m_off(size, addr));
        if (size == 1) return 32'(3 << m_off(size, addr));
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int size, input logic [31:0] wd);
        if (size == 0) return (wd % 256) * 32'h0101_0101;
        if (size == 1) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input int size, input bit uns, input int unsigned addr);
        logic [31:0] w;
        logic [31:0] v;
        w = gold_mem[(addr / 4) % 256] >> (8 * m_off(size, addr));
        if (size == 0) begin
            v = w % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = w % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic m_store(input int size, input int unsigned addr, input logic [31:0] wd);
        logic [31:0] sel;
        logic [31:0] rep;
        logic [31:0] mask;
        int idx;
        sel = m_sel(size, addr);
        rep = m_wdata(size, wd);
        idx = int'((addr / 4) % 256);
        for (int i = 0; i < 4; i++) begin
            if (((sel >> i) % 2) == 1) begin
                mask = 32'hFF << (8 * i);
                gold_mem[idx] = (gold_mem[idx] & ~mask) | (rep & mask);
            end
        end
    endtask

    task automatic reinit_gold();
        for (int i = 0; i < 256; i++) gold_mem[i] = init_word(i);
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        gold_mem[addr[9:2]] = val;
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = addr[9:2];
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic drive_req(input bit we, input logic [1:0] size, input bit uns,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
    endtask

    // One full transaction with fixed-latency expectations and a response stall.
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int stall, output logic [31:0] got);
        bit          ale;
        logic [31:0] exp_data;
        ale      = m_ale(int'(size), addr);
        exp_data = (we || ale) ? 32'h0 : m_load(int'(size), uns, addr);
        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        drive_req(we, size, uns, addr, wd, rd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        if (!ale) begin
            @(negedge clk);
            check("access_ram_en", 32'(bus.ram_en), 32'd1);
            check("access_ram_we", 32'(bus.ram_we), 32'(we));
            check("access_ram_addr", bus.ram_addr, addr & 32'hFFFF_FFFC);
            check("access_ram_sel", 32'(bus.ram_sel), m_sel(int'(size), addr));
            if (we) check("access_ram_wdata", bus.ram_wdata, m_wdata(int'(size), wd));
            check("access_req_ready", 32'(bus.req_ready), 32'd0);
            check("access_resp_valid", 32'(bus.resp_valid), 32'd0);
            if (we) m_store(int'(size), addr, wd);
        end
        @(negedge clk);
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_data", bus.resp_data, exp_data);
        check("resp_rd", 32'(bus.resp_rd), 32'(rd));
        check("resp_ale", 32'(bus.resp_ale), 32'(ale));
        check("resp_ram_en", 32'(bus.ram_en), 32'd0);
        got = bus.resp_data;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_resp_data", bus.resp_data, exp_data);
            check("stall_resp_rd", 32'(bus.resp_rd), 32'(rd));
            check("stall_req_ready", 32'(bus.req_ready), 32'd0);
            check("stall_ram_en", 32'(bus.ram_en), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] wd;
        logic [31:0] ad;
        int          sz;

        rst = 1'b1;
        flush = 1'b0;
        pre_en = 1'b0;
        pre_idx = 8'h0;
        pre_val = 32'h0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_rd = 5'h0;
        bus.resp_ready = 1'b0;
        reinit_gold();

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_ram_en", 32'(bus.ram_en), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("post_rst_resp_data", bus.resp_data, 32'd0);
        check("post_rst_resp_rd", 32'(bus.resp_rd), 32'd0);
        check("post_rst_resp_ale", 32'(bus.resp_ale), 32'd0);
        check("post_rst_ram_en", 32'(bus.ram_en), 32'd0);
        check("post_rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("post_rst_ram_sel", 32'(bus.ram_sel), 32'd0);
        check("post_rst_ram_addr", bus.ram_addr, 32'd0);
        check("post_rst_ram_wdata", bus.ram_wdata, 32'd0);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed cases
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd1, 0, got);
        check("st_word_resp_zero", got, 32'h0);
        check("st_word_committed", ram_mem[8'h40], 32'hDEAD_BEEF);

        preload(32'h100, 32'h0);
        do_req(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_005A, 5'd2, 0, got);
        check("st_byte_committed", ram_mem[8'h40], 32'h5A00_0000);
        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd3, 0, got);
        check("ld_byte_pos", got, 32'h0000_005A);
        preload(32'h100, 32'h8000_0000);
        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 5'd4, 0, got);
        check("ld_byte_signed", got, 32'hFFFF_FF80);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 5'd5, 0, got);
        check("ld_byte_unsigned", got, 32'h0000_0080);

        preload(32'h200, 32'hBEEF_1234);
        do_req(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 5'd6, 0, got);
        check("ld_half_unsigned", got, 32'h0000_BEEF);

        do_req(1'b0, 2'b10, 1'b0, 32'h301, 32'h0, 5'd7, 0, got);
        check("ld_word_misaligned", got, ALE_ON ? 32'h0 : gold_mem[8'hC0]);

        // Long response stall
        do_req(1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 5'd8, 5, got);
        check("stall_word_data", got, 32'hBEEF_1234);

        // Flush in IDLE: request not accepted
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h040, 32'h1111_2222, 5'd9);
        flush = 1'b1;
        @(posedge clk);
        #1 begin bus.req_valid = 1'b0; flush = 1'b0; end
        @(negedge clk);
        check("flush_idle_ram_en", 32'(bus.ram_en), 32'd0);
        check("flush_idle_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("flush_idle_req_ready", 32'(bus.req_ready), 32'd1);
        check("flush_idle_no_write", ram_mem[8'h10], gold_mem[8'h10]);

        // Flush in ACCESS of a store: write commits, no response
        @(negedge clk);
        drive_req(1'b1, 2'b10, 1'b0, 32'h3F0, 32'hCAFE_F00D, 5'd10);
        @(posedge clk);
        #1 begin bus.req_valid = 1'b0; flush = 1'b1; end
        @(negedge clk);
        check("flush_acc_ram_en", 32'(bus.ram_en), 32'd1);
        check("flush_acc_ram_we", 32'(bus.ram_we), 32'd1);
        m_store(2, 32'h3F0, 32'hCAFE_F00D);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_acc_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("flush_acc_req_ready", 32'(bus.req_ready), 32'd1);
        check("flush_acc_committed", ram_mem[8'hFC], 32'hCAFE_F00D);

        // Flush in RESP: response dropped
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 5'd11);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("flush_resp_valid_before", 32'(bus.resp_valid), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_resp_valid_after", 32'(bus.resp_valid), 32'd0);
        check("flush_resp_req_ready", 32'(bus.req_ready), 32'd1);

        // Reset during ACCESS
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 5'd12);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("rst_acc_ram_en_before", 32'(bus.ram_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_acc_ram_en_after", 32'(bus.ram_en), 32'd0);
        check("rst_acc_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_acc_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        reinit_gold();
        @(negedge clk);
        check("rst_acc_resp_valid2", 32'(bus.resp_valid), 32'd0);
        check("rst_acc_req_ready2", 32'(bus.req_ready), 32'd1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            sz = int'($urandom_range(0, 3));
            ad = 32'($urandom_range(0, 1023));
            wd = $urandom;
            do_req(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), ad, wd,
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), got);
        end

        // Whole-memory comparison with the model
        for (int i = 0; i < 256; i++) begin
            if (ram_mem[i] !== gold_mem[i]) check("final_mem", ram_mem[i], gold_mem[i]);
        end
        check("final_mem_word0", ram_mem[0], gold_mem[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
